// File: rtl/uart_tx_if.sv
// Byte-request and serial-status bundle between a UART transmitter and its feeder.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  TX_OUT;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, busy, frame_done
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, busy, frame_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop; each bit lasts
// Prescale clock cycles. All outputs come straight from flops.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic     uart_tx_clk,
    input  logic     uart_tx_rst,
    uart_tx_if.slave tx_if
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]      LAST_BIT     = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(4);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nxt;
    logic [PRESCALE_W-1:0] edge_cnt, edge_cnt_nxt;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [BIT_W-1:0]      bit_idx, bit_idx_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  parity_q;
    logic                  tx_out_q, busy_q, frame_done_q;
    logic                  tx_nxt, frame_done_nxt;
    logic                  bit_end;
    logic                  accept;

    function automatic logic [PRESCALE_W-1:0] clamp_prescale(input logic [PRESCALE_W-1:0] p);
        return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
    endfunction

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign accept  = (state == IDLE) && tx_if.Data_Valid;
    assign bit_end = (edge_cnt == prescale_q - PRESCALE_W'(1));

    always_comb begin
        state_nxt    = state;
        edge_cnt_nxt = edge_cnt;
        bit_idx_nxt  = bit_idx;
        if (state == IDLE) begin
            edge_cnt_nxt = '0;
            bit_idx_nxt  = '0;
            if (tx_if.Data_Valid)
                state_nxt = START;
        end else if (!bit_end) begin
            edge_cnt_nxt = edge_cnt + PRESCALE_W'(1);
        end else begin
            edge_cnt_nxt = '0;
            case (state)
                START: begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
                DATA: begin
                    if (bit_idx == LAST_BIT)
                        state_nxt = par_en_q ? PARITY : STOP;
                    else
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                end
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Line level and done pulse are decoded from the next state so they register cleanly.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_q[bit_idx_nxt];
            PARITY:  tx_nxt = parity_q;
            default: tx_nxt = 1'b1;
        endcase
        frame_done_nxt = (state_nxt == STOP) && (edge_cnt_nxt == prescale_q - PRESCALE_W'(1));
    end

    always_ff @(posedge uart_tx_clk) begin
        if (uart_tx_rst) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_idx      <= '0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            parity_q     <= 1'b0;
            prescale_q   <= MIN_PRESCALE;
            tx_out_q     <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            edge_cnt     <= edge_cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            tx_out_q     <= tx_nxt;
            busy_q       <= (state_nxt != IDLE);
            frame_done_q <= frame_done_nxt;
            if (accept) begin
                data_q     <= tx_if.P_DATA;
                par_en_q   <= tx_if.PAR_EN;
                parity_q   <= calc_parity(tx_if.P_DATA, tx_if.PAR_TYP);
                prescale_q <= clamp_prescale(tx_if.Prescale);
            end
        end
    end

    assign tx_if.TX_OUT     = tx_out_q;
    assign tx_if.busy       = busy_q;
    assign tx_if.frame_done = frame_done_q;
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART frame transmitter, the transmit-side counterpart of the UART_RX receiver path. It runs on the same oversampled clock as the receiver and uses the same Prescale convention, so one bit time equals Prescale clock cycles. It accepts a parallel byte with a valid strobe, builds a start/data/parity/stop frame sent LSB first, and drives the serial line. It reports busy and a one-cycle done pulse so an upstream FIFO or controller can pace bytes.

Parameters:
DATA_WIDTH, 8, payload bits per frame.
PRESCALE_W, 6, width of the Prescale input. Supported ratios are 8, 16 and 32.

Ports:
uart_tx_clk  input  1  oversampled clock; the only clock.
uart_tx_rst  input  1  synchronous, active-high reset.
P_DATA  input  DATA_WIDTH  parallel byte to send.
Data_Valid  input  1  request strobe; sampled only in IDLE.
PAR_EN  input  1  1 = a parity bit is inserted after the data bits.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescale  input  PRESCALE_W  clock cycles per bit.
TX_OUT  output  1  serial line; idles high.
busy  output  1  high while a frame is in flight.
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- One clock (uart_tx_clk); reset uart_tx_rst is synchronous and active-high.
- Reset values: TX_OUT=1, busy=0, frame_done=0, FSM in IDLE, edge and bit counters at 0, data and parity registers cleared. Reset asserted mid-frame aborts the frame: on the next edge TX_OUT=1, busy=0 and the frame is dropped. No partial resume.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance: in IDLE, a rising edge with Data_Valid=1 latches P_DATA, PAR_EN, PAR_TYP and Prescale, and computes parity = (XOR of P_DATA) XOR PAR_TYP. Next state is START.
- Data_Valid outside IDLE is ignored. There is no queuing.
- Inputs changing after acceptance do not affect the frame in flight.
- Latency: acceptance at edge N gives TX_OUT=0 and busy=1 from the cycle after edge N.
- Bit timing: an edge counter counts 0..Prescale_latched-1 in every non-IDLE state. At terminal count it resets to 0 and the state or bit index advances, so each bit lasts exactly Prescale_latched cycles.
- Prescale clamp: a latched Prescale below 4 is treated as 4. Values are not otherwise checked.
- START: TX_OUT=0 for one bit time, then DATA.
- DATA: TX_OUT=data[bit_idx], with bit_idx counting 0..DATA_WIDTH-1 (LSB first). After the last data bit, go to PARITY if PAR_EN_latched, else STOP.
- PARITY: TX_OUT = the latched parity bit for one bit time, then STOP.
- STOP: TX_OUT=1 for one bit time. frame_done=1 on the final cycle of STOP only. The next state is IDLE.
- busy is 0 in the cycle after the final STOP cycle.
- Frame length: (DATA_WIDTH+2) x Prescale cycles without parity, (DATA_WIDTH+3) x Prescale cycles with parity.
- Back-to-back frames: Data_Valid held high continuously gives exactly one IDLE cycle (TX_OUT=1) between frames. Acceptance happens on that IDLE cycle.
- Outputs are registered. TX_OUT is glitch-free and has no combinational path from any input.
- The edge counter must be wide enough for Prescale=32 without overflow. Wrap-around is never used as a terminator.

Test Plan:
- Reset then idle, no Data_Valid for 50 cycles -> TX_OUT=1, busy=0, frame_done=0 throughout.
- Prescale=8, PAR_EN=0, P_DATA=0xA5, one-cycle Data_Valid -> 80 cycles of busy; bit sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 8 cycles; frame_done on cycle 80; busy=0 on cycle 81.
- Prescale=16, PAR_EN=1, P_DATA=0xA5: with PAR_TYP=0 the parity bit is 0, with PAR_TYP=1 it is 1 -> 176-cycle frame; the parity bit occupies cycles 145-160.
- Data_Valid held high, P_DATA=0x00 then 0xFF, Prescale=8, no parity -> two 80-cycle frames separated by exactly one idle-high cycle; the second frame carries 0xFF. Pulse Data_Valid mid-frame with P_DATA=0x3C -> frame unchanged and 0x3C never sent.
- Assert uart_tx_rst during the DATA state of a 0x55 frame -> TX_OUT=1 and busy=0 on the following cycle; a new 0x0F request after reset sends a clean frame.
- Prescale=32 with 0x80 and no parity -> 320-cycle frame, MSB high for 32 cycles. Prescale=2 -> bits held 4 cycles (clamp).
